// File: rtl/taus_stream_checker.sv
// Receive-side checker for a three-component Tausworthe uniform stream.
// Regenerates the expected sequence from a loaded seed, tracks lock and counts mismatches.
module taus_stream_checker #(
  parameter int unsigned LOCK_THRESH   = 4,
  parameter int unsigned UNLOCK_THRESH = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [31:0] seed0,
  input  logic [31:0] seed1,
  input  logic [31:0] seed2,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        err_pulse,
  output logic        lock,
  output logic [15:0] err_count,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQ     = 3'd1,
    LOCKED  = 3'd2,
    LOST    = 3'd3,
    BADSEED = 3'd4
  } state_t;

  localparam logic [7:0] LOCK_TH   = 8'(LOCK_THRESH);
  localparam logic [7:0] UNLOCK_TH = 8'(UNLOCK_THRESH);

  function automatic logic [31:0] taus_step0(input logic [31:0] e);
    return ((e & 32'hFFFF_FFFE) << 12) ^ (((e << 13) ^ e) >> 19);
  endfunction

  function automatic logic [31:0] taus_step1(input logic [31:0] e);
    return ((e & 32'hFFFF_FFF8) << 4) ^ (((e << 2) ^ e) >> 25);
  endfunction

  function automatic logic [31:0] taus_step2(input logic [31:0] e);
    return ((e & 32'hFFFF_FFF0) << 17) ^ (((e << 3) ^ e) >> 11);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] e0_q, e1_q, e2_q;
  logic [31:0] e0_nx, e1_nx, e2_nx;
  logic [31:0] exp_sample;
  logic [7:0]  match_run_q, match_run_d;
  logic [7:0]  miss_run_q, miss_run_d;
  logic [15:0] err_count_q, err_count_d;
  logic        err_pulse_p1, err_pulse_d;
  logic        seed_ok;
  logic        accept;
  logic        mismatch;

  // Stage p0: expected sample from the current generator state, compare, decide
  assign e0_nx      = taus_step0(e0_q);
  assign e1_nx      = taus_step1(e1_q);
  assign e2_nx      = taus_step2(e2_q);
  assign exp_sample = e0_nx ^ e1_nx ^ e2_nx;

  // Seeds at or below these bounds collapse a component to an all-zero cycle
  assign seed_ok  = (seed0 > 32'd1) && (seed1 > 32'd7) && (seed2 > 32'd15);
  assign in_ready = ((state_q == ACQ) || (state_q == LOCKED) || (state_q == LOST)) && !seed_load;
  assign accept   = in_valid && in_ready;
  assign mismatch = (in_data != exp_sample);

  always_comb begin
    state_d     = state_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    if (seed_load) begin
      state_d     = seed_ok ? ACQ : BADSEED;
      match_run_d = 8'd0;
      miss_run_d  = 8'd0;
      err_count_d = 16'd0;
    end else if (accept) begin
      if (mismatch) begin
        err_pulse_d = 1'b1;
        err_count_d = sat_inc16(err_count_q);
      end
      unique case (state_q)
        ACQ: begin
          if (!mismatch) begin
            match_run_d = sat_inc8(match_run_q);
            if (match_run_d >= LOCK_TH) state_d = LOCKED;
          end else begin
            match_run_d = 8'd0;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            miss_run_d = sat_inc8(miss_run_q);
            if (miss_run_d >= UNLOCK_TH) state_d = LOST;
          end else begin
            miss_run_d = 8'd0;
          end
        end
        default: ;
      endcase
      // Runs are per-state; any transition starts them from zero
      if (state_d != state_q) begin
        match_run_d = 8'd0;
        miss_run_d  = 8'd0;
      end
    end
  end

  // Stage p1: registered state, generator and compare result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      match_run_q  <= 8'd0;
      miss_run_q   <= 8'd0;
      err_count_q  <= 16'd0;
      err_pulse_p1 <= 1'b0;
    end else begin
      state_q      <= state_d;
      match_run_q  <= match_run_d;
      miss_run_q   <= miss_run_d;
      err_count_q  <= err_count_d;
      err_pulse_p1 <= err_pulse_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q <= 32'd0;
      e1_q <= 32'd0;
      e2_q <= 32'd0;
    end else if (seed_load) begin
      if (seed_ok) begin
        e0_q <= seed0;
        e1_q <= seed1;
        e2_q <= seed2;
      end
    end else if (accept) begin
      e0_q <= e0_nx;
      e1_q <= e1_nx;
      e2_q <= e2_nx;
    end
  end

  assign err_pulse = err_pulse_p1;
  assign err_count = err_count_q;
  assign lock      = (state_q == LOCKED);
  assign state     = state_q;

endmodule

// File: tb/tb_taus_stream_checker.sv
// Bench for taus_stream_checker: directed steps plus randomized traffic against a
// sample-level reference model of generator, lock tracking and error counting.
module tb_taus_stream_checker;

  localparam int LT = 2;
  localparam int UT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed0 = '0, seed1 = '0, seed2 = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, err_pulse, lock;
  logic [15:0] err_count;
  logic [2:0]  state;

  int errors = 0;
  int checks = 0;

  bit [31:0] m_e0, m_e1, m_e2;
  int        m_state, m_err, m_mrun, m_xrun;
  bit        m_pulse;

  taus_stream_checker #(.LOCK_THRESH(LT), .UNLOCK_THRESH(UT)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load),
    .seed0(seed0), .seed1(seed1), .seed2(seed2),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .err_pulse(err_pulse), .lock(lock), .err_count(err_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] comp_step(bit [31:0] e, bit [31:0] mask, int a, int b, int c);
    return ((e & mask) << c) ^ (((e << a) ^ e) >> b);
  endfunction

  function automatic bit [31:0] model_expect();
    return comp_step(m_e0, 32'hFFFF_FFFE, 13, 19, 12)
         ^ comp_step(m_e1, 32'hFFFF_FFF8, 2, 25, 4)
         ^ comp_step(m_e2, 32'hFFFF_FFF0, 3, 11, 17);
  endfunction

  function automatic bit model_ready(bit sl);
    return (m_state >= 1) && (m_state <= 3) && !sl;
  endfunction

  task automatic model_reset();
    m_e0 = 0; m_e1 = 0; m_e2 = 0;
    m_state = 0; m_err = 0; m_mrun = 0; m_xrun = 0; m_pulse = 0;
  endtask

  task automatic model_edge(bit sl, bit [31:0] s0, bit [31:0] s1, bit [31:0] s2, bit v, bit [31:0] d);
    bit match;
    m_pulse = 0;
    if (sl) begin
      m_err = 0; m_mrun = 0; m_xrun = 0;
      if (s0 > 1 && s1 > 7 && s2 > 15) begin
        m_e0 = s0; m_e1 = s1; m_e2 = s2; m_state = 1;
      end else begin
        m_state = 4;
      end
    end else if (v && model_ready(0)) begin
      match = (d == model_expect());
      m_e0 = comp_step(m_e0, 32'hFFFF_FFFE, 13, 19, 12);
      m_e1 = comp_step(m_e1, 32'hFFFF_FFF8, 2, 25, 4);
      m_e2 = comp_step(m_e2, 32'hFFFF_FFF0, 3, 11, 17);
      if (!match) begin
        m_pulse = 1;
        if (m_err < 65535) m_err++;
      end
      if (m_state == 1) begin
        m_mrun = match ? ((m_mrun < 255) ? m_mrun + 1 : 255) : 0;
        if (m_mrun >= LT) begin m_state = 2; m_mrun = 0; m_xrun = 0; end
      end else if (m_state == 2) begin
        m_xrun = match ? 0 : ((m_xrun < 255) ? m_xrun + 1 : 255);
        if (m_xrun >= UT) begin m_state = 3; m_mrun = 0; m_xrun = 0; end
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".lock"}, 32'(lock), 32'(m_state == 2));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
  endtask

  // Drive one cycle of inputs, check in_ready combinationally, then check registered outputs.
  task automatic step(string tag, bit sl, bit [31:0] s0, bit [31:0] s1, bit [31:0] s2,
                      bit v, bit [31:0] d);
    seed_load = sl; seed0 = s0; seed1 = s1; seed2 = s2; in_valid = v; in_data = d;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(model_ready(sl)));
    model_edge(sl, s0, s1, s2, v, d);
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    bit [31:0] r0, r1, r2, d;
    bit        sl, v;
    model_reset();

    // Power-on reset
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs("reset");
    check("reset.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // No seed yet: samples ignored
    step("noseed0", 0, 0, 0, 0, 1, 32'h0020_2080);
    step("noseed1", 0, 0, 0, 0, 1, 32'h1234_5678);

    // Known-answer lock with seeds 2/8/16
    step("kat.load", 1, 2, 8, 16, 0, 0);
    step("kat.s1", 0, 0, 0, 0, 1, 32'h0020_2080);
    check("kat.acq", 32'(state), 32'd1);
    step("kat.s2", 0, 0, 0, 0, 1, 32'h0200_2C80);
    check("kat.locked", 32'(lock), 32'd1);

    // First sample wrong; generator still steps
    step("err.load", 1, 2, 8, 16, 0, 0);
    step("err.s1", 0, 0, 0, 0, 1, 32'h0020_2081);
    check("err.pulse", 32'(err_pulse), 32'd1);
    check("err.count", 32'(err_count), 32'd1);
    step("err.s2", 0, 0, 0, 0, 1, 32'h0200_2C80);
    check("err.nopulse", 32'(err_pulse), 32'd0);
    step("err.gap", 0, 0, 0, 0, 0, 0);

    // Bad seed, then recovery
    step("bad.load", 1, 1, 8, 16, 0, 0);
    step("bad.idle", 0, 0, 0, 0, 1, 32'h0);
    check("bad.state", 32'(state), 32'd4);
    step("bad.good", 1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0, 0);
    check("bad.acq", 32'(state), 32'd1);

    // Lock, then 2 wrong, 1 right, 3 wrong -> LOST
    step("ul.m1", 0, 0, 0, 0, 1, model_expect());
    step("ul.m2", 0, 0, 0, 0, 1, model_expect());
    step("ul.x1", 0, 0, 0, 0, 1, ~model_expect());
    step("ul.x2", 0, 0, 0, 0, 1, model_expect() ^ 32'h8000_0000);
    step("ul.r1", 0, 0, 0, 0, 1, model_expect());
    step("ul.x3", 0, 0, 0, 0, 1, ~model_expect());
    step("ul.x4", 0, 0, 0, 0, 1, ~model_expect());
    check("ul.still_locked", 32'(lock), 32'd1);
    step("ul.x5", 0, 0, 0, 0, 1, ~model_expect());
    check("ul.lost", 32'(state), 32'd3);
    check("ul.errs", 32'(err_count), 32'd5);
    step("lost.x", 0, 0, 0, 0, 1, 32'hDEAD_BEEF ^ model_expect());
    step("lost.m", 0, 0, 0, 0, 1, model_expect());

    // seed_load wins over a coincident sample in LOCKED
    step("pre.load", 1, 2, 8, 16, 0, 0);
    step("pre.m1", 0, 0, 0, 0, 1, model_expect());
    step("pre.x", 0, 0, 0, 0, 1, ~model_expect());
    step("pre.m2", 0, 0, 0, 0, 1, model_expect());
    step("pre.m3", 0, 0, 0, 0, 1, model_expect());
    check("pre.locked", 32'(state), 32'd2);
    step("pre.both", 1, 2, 8, 16, 1, 32'hFFFF_FFFF);
    check("pre.acq", 32'(state), 32'd1);
    step("pre.after", 0, 0, 0, 0, 1, 32'h0020_2080);

    // Randomized traffic with occasional reseeds
    for (int i = 0; i < 400; i++) begin
      sl = ($urandom_range(0, 99) < 4);
      r0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 17)) : $urandom;
      v  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 4) == 0) ? $urandom : model_expect();
      step("rand", sl, r0, r1, r2, v, d);
    end

    // Drive to LOST and saturate err_count
    step("sat.load", 1, 32'hCAFE_0001, 32'hBEEF_0010, 32'h1234_5670, 0, 0);
    step("sat.m1", 0, 0, 0, 0, 1, model_expect());
    step("sat.m2", 0, 0, 0, 0, 1, model_expect());
    for (int i = 0; i < 65540; i++) begin
      seed_load = 0; in_valid = 1; in_data = ~model_expect();
      model_edge(0, 0, 0, 0, 1, in_data);
      @(posedge clk); #1;
    end
    check_outputs("sat");
    check("sat.count", 32'(err_count), 32'hFFFF);
    step("sat.more", 0, 0, 0, 0, 1, ~model_expect());
    check("sat.pulse", 32'(err_pulse), 32'd1);

    // Asynchronous reset mid-stream
    seed_load = 0; in_valid = 1; in_data = model_expect();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    check("arst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("arst.idle", 0, 0, 0, 0, 1, 32'h0020_2080);
    step("arst.load", 1, 2, 8, 16, 0, 0);
    step("arst.s1", 0, 0, 0, 0, 1, 32'h0020_2080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/taus_stream_checker.md
TAUS_STREAM_CHECKER -- requirements
Module: taus_stream_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 4: consecutive matching samples required to declare lock (range 1..255).
REQ-002 Parameter UNLOCK_THRESH, default 3: consecutive mismatching samples in LOCKED that declare loss of lock (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 seed_load  input  1  one-cycle strobe; loads seed0..seed2 into the expected-state registers.
REQ-006 seed0, seed1, seed2  input  32 each  seeds for the three Tausworthe component registers.
REQ-007 in_valid  input  1  in_data holds a received uniform sample.
REQ-008 in_data  input  32  received uniform sample.
REQ-009 in_ready  output  1  checker accepts a sample this cycle; sample accepted when in_valid && in_ready.
REQ-010 err_pulse  output  1  one-cycle pulse: the previously accepted sample mismatched.
REQ-011 lock  output  1  high exactly while state is LOCKED.
REQ-012 err_count  output  16  total mismatches since last seed_load, saturating at 16'hFFFF.
REQ-013 state  output  3  FSM state: IDLE=0, ACQ=1, LOCKED=2, LOST=3, BADSEED=4.

Function
REQ-014 Expected generator: registers e0,e1,e2 (32 bits each); one step computes, modulo 2^32: e0' = ((e0 & FFFFFFFE)<<12) ^ (((e0<<13)^e0)>>19); e1' = ((e1 & FFFFFFF8)<<4) ^ (((e1<<2)^e1)>>25); e2' = ((e2 & FFFFFFF0)<<17) ^ (((e2<<3)^e2)>>11); expected sample = e0'^e1'^e2'.
REQ-015 Each accepted sample is compared with the expected sample computed from the current e0..e2; e0..e2 then step to e0'..e2' on that edge, match or mismatch.
REQ-016 in_ready = 1 only in ACQ, LOCKED or LOST and seed_load low (combinational on seed_load); 0 in IDLE and BADSEED.
REQ-017 seed_load valid iff seed0 > 1, seed1 > 7, seed2 > 15 (unsigned); valid load -> e0..e2 = seeds, err_count = 0, run counters = 0, state = ACQ; invalid load -> state = BADSEED, e0..e2 unchanged, err_count = 0.
REQ-018 seed_load takes precedence over any other event in the same cycle, from any state; a coincident in_valid sample is not accepted.
REQ-019 Compare result is registered: err_pulse and err_count reflect an accepted sample on the edge at which it is accepted (visible the following cycle); latency 1 cycle.
REQ-020 ACQ: match increments match run; mismatch clears match run and increments err_count; match run reaching LOCK_THRESH -> LOCKED on that edge (LOCK_THRESH=1 locks on first match).
REQ-021 LOCKED: mismatch increments miss run and err_count; match clears miss run; miss run reaching UNLOCK_THRESH -> LOST.
REQ-022 LOST: samples still accepted, compared and counted; state held until seed_load or reset.
REQ-023 err_count stops at 16'hFFFF; further mismatches still pulse err_pulse.
REQ-024 Cycles without acceptance: no stepping, no counter change, err_pulse 0.
REQ-025 Run counters 8 bits, saturating; cleared on every state transition.

Reset
REQ-026 rst_n low, any time including mid-stream: state = IDLE, e0..e2 = 0, err_count = 0, run counters = 0, err_pulse = 0, lock = 0, in_ready = 0; operation resumes only after rst_n high and a seed_load.

Verification
REQ-027 Reset released, no seed_load -> state 0, in_ready 0, lock 0, err_count 0; in_valid ignored.
REQ-028 LOCK_THRESH=2; seed_load with 2, 8, 16; send 32'h00202080 then 32'h02002C80 -> no err_pulse, state ACQ after first, LOCKED/lock=1 after second.
REQ-029 Same seeds; first sample 32'h00202081 -> err_pulse one cycle later, err_count 1, state ACQ; next sample 32'h02002C80 still matches (generator stepped).
REQ-030 seed_load with seed0=1, seed1=8, seed2=16 -> state 4, in_ready 0; subsequent valid load -> state 1.
REQ-031 LOCKED with UNLOCK_THRESH=3; 2 wrong, 1 right, 3 wrong -> LOST after sixth sample, lock 0, err_count +5.
REQ-032 seed_load and in_valid high same cycle in LOCKED -> in_ready 0, sample not accepted, state ACQ, err_count 0; rst_n pulsed mid-stream -> all outputs at reset values immediately.
